pe_scratchpad_window: RTL

- Circular scratchpad sitting directly downstream of the PE read controller.
- Stores input words written through the controller's wen_SP / inc_write_cnt handshake and drives that controller's permission input.
- Serves fixed-size KSIZE-word windows to the MAC stage, then releases `stride` words per window (sliding-window convolution).
- Holds the write/read pointers and the occupancy counter for the PE input path.

---
 rtl/pe_scratchpad_window.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pe_scratchpad_window.sv
// Circular input scratchpad for a PE: the writer fills it through a store/commit handshake and
// the MAC stage reads fixed KSIZE-word windows, each releasing `stride` words when it finishes.
module pe_scratchpad_window #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned KSIZE  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen_SP,
  input  logic [WIDTH-1:0]  din,
  input  logic              inc_write_cnt,
  output logic              permission,
  input  logic [ADDR_W-1:0] stride,
  input  logic              win_start,
  output logic              win_busy,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_valid,
  output logic              dout_last,
  output logic              win_done,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   DepthC = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   KsizeC = KSIZE[ADDR_W:0];
  localparam logic [ADDR_W-1:0] KLast  = ADDR_W'(KSIZE - 1);

  typedef enum logic [1:0] {StIdle, StWait, StRead, StRelease} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rbase_q, rbase_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   stride_q, stride_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              dout_last_q, dout_last_d;
  logic              win_done_q, win_done_d;

  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              not_full;
  logic              commit;
  logic              release_win;
  logic [ADDR_W:0]   stride_ext;
  logic [ADDR_W:0]   stride_sat;
  logic [ADDR_W-1:0] rd_addr;

  assign not_full   = count_q < DepthC;
  assign commit     = inc_write_cnt && not_full;
  assign stride_ext = {1'b0, stride};
  assign rd_addr    = rbase_q + k_q;

  always_comb begin
    stride_sat = stride_ext;
    if (stride_ext == '0) begin
      stride_sat = (ADDR_W + 1)'(1);
    end else if (stride_ext > KsizeC) begin
      stride_sat = KsizeC;
    end
  end

  // Storage has no reset; its contents are only read once committed.
  always_ff @(posedge clk) begin
    if (wen_SP && not_full) begin
      mem_q[wptr_q] <= din;
    end
  end

  always_comb begin
    state_d      = state_q;
    rbase_d      = rbase_q;
    k_d          = k_q;
    stride_d     = stride_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    dout_last_d  = 1'b0;
    win_done_d   = 1'b0;
    release_win  = 1'b0;
    case (state_q)
      StIdle: begin
        if (win_start) begin
          stride_d = stride_sat;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (count_q >= KsizeC) begin
          k_d     = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        dout_d       = mem_q[rd_addr];
        dout_valid_d = 1'b1;
        dout_last_d  = (k_q == KLast);
        k_d          = k_q + 1'b1;
        if (k_q == KLast) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        // A stride equal to DEPTH truncates to a full lap, leaving rbase unchanged.
        rbase_d     = rbase_q + stride_q[ADDR_W-1:0];
        release_win = 1'b1;
        win_done_d  = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wptr_d  = commit ? wptr_q + 1'b1 : wptr_q;
    count_d = count_q + (ADDR_W + 1)'(commit) - (release_win ? stride_q : '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      wptr_q       <= '0;
      rbase_q      <= '0;
      k_q          <= '0;
      count_q      <= '0;
      stride_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      win_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      rbase_q      <= rbase_d;
      k_q          <= k_d;
      count_q      <= count_d;
      stride_q     <= stride_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      win_done_q   <= win_done_d;
    end
  end

  assign permission = not_full;
  assign win_busy   = (state_q != StIdle);
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign win_done   = win_done_q;
  assign count      = count_q;

endmodule
